// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// A two-flop synchronizer feeds a start/data/stop sampling FSM. Completed bytes
// are buffered in a small FIFO that is drained through a valid/ready handshake.
// Framing errors and overflows are reported as single-cycle pulses.
`timescale 1ns/1ps
module uart_rx #(
    parameter int CLOCK_FREQ  = 50000000,
    parameter int BAUD_RATE   = 115200,
    parameter int BUFFER_SIZE = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    output logic [7:0]                     data_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic                           frame_error_o,
    output logic                           overflow_o,
    output logic                           busy_o,
    output logic [$clog2(BUFFER_SIZE):0]   level_o
);

    localparam int CPB   = CLOCK_FREQ / BAUD_RATE;
    localparam int CNT_W = $clog2(CPB);
    localparam int PTR_W = $clog2(BUFFER_SIZE);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(BUFFER_SIZE);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    logic             r_rx_meta;
    logic             r_rx_s;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shreg;
    logic             r_frame_err;
    logic             r_busy;
    logic             r_overflow;
    logic [7:0]       r_mem [BUFFER_SIZE];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_stop_ok;
    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A good stop bit is sampled this cycle; the byte goes to the FIFO on the same edge.
    assign w_stop_ok = (r_state == S_STOP) && (r_cnt == CNT_LAST) && r_rx_s;
    assign w_full    = (r_level == LVL_FULL);
    assign w_empty   = (r_level == {LVL_W{1'b0}});
    assign w_pop     = !w_empty && ready_i;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the byte.
    assign w_push    = w_stop_ok && (!w_full || w_pop);
    assign w_drop    = w_stop_ok && w_full && !w_pop;

    // Two-flop synchronizer for the asynchronous rx pin, idle-high after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Receive FSM: find start edge, confirm it mid-bit, sample 8 data bits and the stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_idx       <= 3'd0;
            r_shreg     <= 8'h00;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            // Start bit vanished before mid-bit: treat as a glitch.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= {CNT_W{1'b0}};
                        r_shreg[r_idx] <= r_rx_s;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (r_rx_s) begin
                            // Returning to IDLE here lets a back-to-back start edge be caught.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_WAIT: begin
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage: written on push; cleared on reset so data_o reads 0 afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= r_shreg;
        end
    end

    // FIFO pointers, occupancy and overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_level    <= {LVL_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_drop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign data_o        = r_mem[r_rd_ptr];
    assign valid_o       = !w_empty;
    assign level_o       = r_level;
    assign frame_error_o = r_frame_err;
    assign overflow_o    = r_overflow;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx with CPB=10 and a 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic       frame_error_o;
    logic       overflow_o;
    logic       busy_o;
    logic [2:0] level_o;

    int n_cmp = 0;
    int n_err = 0;
    int n_fe  = 0;
    int n_ov  = 0;
    logic [7:0] sb[$];

    uart_rx #(
        .CLOCK_FREQ (1000000),
        .BAUD_RATE  (100000),
        .BUFFER_SIZE(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (rx),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .frame_error_o(frame_error_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o),
        .level_o      (level_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One 8N1 frame, 10 clocks per bit. Optionally raises ready_i for exactly the
    // stop-sample cycle (98th edge after the start bit is driven).
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic pop_at_stop);
        rx = 1'b0;
        wait_clks(10);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(10);
        end
        rx = stop_val;
        wait_clks(7);
        if (pop_at_stop) ready_i = 1'b1;
        wait_clks(1);
        ready_i = 1'b0;
        wait_clks(2);
        rx = 1'b1;
    endtask

    task automatic drain(input int n);
        ready_i = 1'b1;
        wait_clks(n);
        ready_i = 1'b0;
    endtask

    // Monitor: compare every handshaken byte against the scoreboard; count flag pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_pop: got %0h, expected no byte", data_o);
                end else begin
                    chk("pop_data", {24'h0, data_o}, {24'h0, sb.pop_front()});
                end
            end
            if (frame_error_o) n_fe++;
            if (overflow_o)    n_ov++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen_idle;
        rst = 1'b1;
        rx = 1'b1;
        ready_i = 1'b0;
        wait_clks(3);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_data", data_o, 8'h00);
        chk("rst_level", level_o, 3'd0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_fe", frame_error_o, 1'b0);
        chk("rst_ov", overflow_o, 1'b0);
        rst = 1'b0;
        wait_clks(5);

        // 1: single byte, held then popped
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(2);
        chk("t1_valid", valid_o, 1'b1);
        chk("t1_data", data_o, 8'hA5);
        chk("t1_level", level_o, 3'd1);
        chk("t1_busy", busy_o, 1'b0);
        drain(1);
        chk("t1_valid_after_pop", valid_o, 1'b0);
        chk("t1_level_after_pop", level_o, 3'd0);

        // 2: short glitch on the line
        rx = 1'b0;
        wait_clks(3);
        chk("t2_busy_seen", busy_o, 1'b1);
        rx = 1'b1;
        seen_idle = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_clks(1);
            if (!busy_o) begin
                seen_idle = 1'b1;
                break;
            end
        end
        chk("t2_busy_cleared", seen_idle, 1'b1);
        wait_clks(5);
        chk("t2_level", level_o, 3'd0);
        chk("t2_flags", n_fe + n_ov, 0);

        // 3: framing error, then a good byte
        send_frame(8'h3C, 1'b0, 1'b0);
        wait_clks(10);
        chk("t3_fe_count", n_fe, 1);
        chk("t3_level", level_o, 3'd0);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clks(2);
        chk("t3_data", data_o, 8'h55);
        chk("t3_level2", level_o, 3'd1);
        drain(1);

        // 4: overflow on the fifth byte
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) sb.push_back(8'(i));
            send_frame(8'(i), 1'b1, 1'b0);
        end
        wait_clks(2);
        chk("t4_level", level_o, 3'd4);
        chk("t4_ov_count", n_ov, 1);
        drain(5);
        chk("t4_level_empty", level_o, 3'd0);
        chk("t4_valid_empty", valid_o, 1'b0);

        // 5: reset mid-frame with a byte buffered
        send_frame(8'h5A, 1'b1, 1'b0);
        wait_clks(2);
        chk("t5_pre_level", level_o, 3'd1);
        rx = 1'b0;
        wait_clks(10);
        rx = 1'b1;
        wait_clks(10);
        rx = 1'b0;
        wait_clks(10);
        rst = 1'b1;
        rx = 1'b1;
        #1;
        chk("t5_rst_valid", valid_o, 1'b0);
        chk("t5_rst_level", level_o, 3'd0);
        chk("t5_rst_busy", busy_o, 1'b0);
        chk("t5_rst_data", data_o, 8'h00);
        wait_clks(3);
        rst = 1'b0;
        wait_clks(20);
        sb.push_back(8'h88);
        send_frame(8'h88, 1'b1, 1'b0);
        wait_clks(2);
        chk("t5_level", level_o, 3'd1);
        chk("t5_data", data_o, 8'h88);
        drain(1);

        // 6: push and pop in the same cycle while full
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        sb.push_back(8'h44);
        sb.push_back(8'hC3);
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        send_frame(8'h33, 1'b1, 1'b0);
        send_frame(8'h44, 1'b1, 1'b0);
        wait_clks(2);
        chk("t6_full", level_o, 3'd4);
        send_frame(8'hC3, 1'b1, 1'b1);
        wait_clks(2);
        chk("t6_level", level_o, 3'd4);
        chk("t6_ov_count", n_ov, 1);
        chk("t6_fe_count", n_fe, 1);
        drain(4);
        chk("t6_level_empty", level_o, 3'd0);
        chk("t6_sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
